// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bus bundle between the fetch stage, the load/store unit,
//               the unified memory and mem_arbiter.
//               Fetch side : if_req, if_addr -> if_rdata, if_done, if_stall
//               Data side  : dm_req, dm_we, dm_addr, dm_wdata
//                            -> dm_rdata, dm_done, dm_stall
//               Ownership  : grant_if, grant_dm
//               Memory side: mem_req, mem_we, mem_addr, mem_wdata
//                            <- mem_rdata, mem_ready
//               slave  = arbiter view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_done;
    logic                  if_stall;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_done;
    logic                  dm_stall;

    logic                  grant_if;
    logic                  grant_dm;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               grant_if, grant_dm, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               grant_if, grant_dm, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbiter/sequencer sharing one single-ported memory between
//               instruction fetch and the load/store unit. Data accesses win
//               arbitration; a saturating starvation counter forces a fetch
//               grant after STARVE_LIMIT consecutive data grants taken while
//               fetch was waiting. Each access runs IDLE -> BUSY -> RESP.
// Ports       : clk - clock, rising edge
//               rst - asynchronous active-high reset
//               bus - mem_arbiter_if.slave (request, response, memory bus)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_arbiter_if.slave     bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int                 c_cnt_w      = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  w_grant_dm;
    logic                  w_grant_if;

    logic                  r_owner_dm;   // 1 = data side owns the access
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_cnt_w-1:0]    r_starve_cnt;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and grant decision. Requests are only looked at in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_dm  = 1'b0;
        w_grant_if  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.dm_req && !(bus.if_req && (r_starve_cnt == c_starve_max))) begin
                    w_grant_dm  = 1'b1;
                    w_state_nxt = S_BUSY;
                end else if (bus.if_req) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.mem_ready) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, starvation counter and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_dm   <= 1'b0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_starve_cnt <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            if (w_grant_dm) begin
                r_owner_dm <= 1'b1;
                r_addr     <= bus.dm_addr;
                r_we       <= bus.dm_we;
                r_wdata    <= bus.dm_wdata;
                // Only a data grant that leaves fetch waiting counts as starving it
                if (!bus.if_req) begin
                    r_starve_cnt <= '0;
                end else if (r_starve_cnt != c_starve_max) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else if (w_grant_if) begin
                r_owner_dm   <= 1'b0;
                r_addr       <= bus.if_addr;
                r_we         <= 1'b0;
                r_wdata      <= '0;
                r_starve_cnt <= '0;
            end

            // Stores complete without touching the read-data registers
            if ((r_state == S_BUSY) && bus.mem_ready && !r_we) begin
                if (r_owner_dm) begin
                    r_dm_rdata <= bus.mem_rdata;
                end else begin
                    r_if_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_req   = (r_state == S_BUSY);
    assign bus.mem_we    = (r_state == S_BUSY) && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    assign bus.grant_dm  = (r_state != S_IDLE) &&  r_owner_dm;
    assign bus.grant_if  = (r_state != S_IDLE) && !r_owner_dm;

    assign bus.dm_done   = (r_state == S_RESP) &&  r_owner_dm;
    assign bus.if_done   = (r_state == S_RESP) && !r_owner_dm;

    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;

    // Stalls are masked by rst so they read 0 for the whole reset window
    assign bus.if_stall  = bus.if_req && !bus.if_done && !rst;
    assign bus.dm_stall  = bus.dm_req && !bus.dm_done && !rst;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for a single-ported unified instruction/data memory. It shares the memory between the fetch stage and the load/store unit, and it owns the memory-side handshake and the stall signals. Fetch requests come from the PC path and data requests from the ALUResult/WriteData path. Data accesses have priority, and a starvation counter guarantees fetch forward progress.

## Interface
Parameters:
- DATA_WIDTH, 32, width of data words
- ADDR_WIDTH, 32, width of byte addresses
- STARVE_LIMIT, 4, number of consecutive data grants allowed while fetch waits (≥1)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; asynchronous, active-high
- if_req  input  1  fetch request; level, held until if_done
- if_addr  input  ADDR_WIDTH  fetch address; stable while if_req is high
- if_rdata  output  DATA_WIDTH  fetched instruction; registered
- if_done  output  1  one-cycle pulse; if_rdata is valid in this cycle
- if_stall  output  1  if_req & ~if_done
- dm_req  input  1  data request; level, held until dm_done
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  ADDR_WIDTH  data address
- dm_wdata  input  DATA_WIDTH  store data
- dm_rdata  output  DATA_WIDTH  load data; registered
- dm_done  output  1  one-cycle pulse at completion
- dm_stall  output  1  dm_req & ~dm_done
- grant_if, grant_dm  output  1 each  current memory owner; one-hot or both 0
- mem_req  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data; valid when mem_ready=1
- mem_ready  input  1  access complete

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Grant DM if dm_req and not (if_req and starve_cnt==STARVE_LIMIT).
  - Otherwise grant IF if if_req.
  - Otherwise stay in IDLE.
  - On a grant: latch owner, address, we and wdata into registers, then go to BUSY.
  - A fetch grant always latches we=0.
- BUSY:
  - mem_req=1; mem_addr/mem_we/mem_wdata driven from the latch registers.
  - Wait for mem_ready.
  - On mem_ready: capture mem_rdata into the owner's rdata register, only for reads; go to RESP.
  - A store leaves dm_rdata unchanged.
- RESP:
  - Pulse the owner's done for exactly one cycle; mem_req=0; no grant in this state.
  - Go to IDLE. This lets the requester drop or replace its req before the next arbitration.
- Starvation counter (starve_cnt, 0..STARVE_LIMIT, saturating), updated at each grant:
  - DM grant with if_req=1: increment.
  - IF grant, or any grant with if_req=0: clear.
- grant_if/grant_dm are high in BUSY and RESP for the owner, 0 in IDLE.
- Requester inputs are ignored outside IDLE. Changes to address or data during BUSY have no effect.

## Timing
- Reset values:
  - state=IDLE, starve_cnt=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_rdata=0, dm_rdata=0, if_done=0, dm_done=0.
  - grant_if=0, grant_dm=0.
- Reset mid-transaction aborts it; no done pulse is ever issued for the aborted access.
- Latency: req sampled in IDLE at edge 0 → mem_req high from cycle 1 → mem_ready in cycle k → done high in cycle k+1.
- With mem_ready in the first BUSY cycle, the minimum is 3 cycles per access (IDLE, BUSY, RESP).
- Simultaneous if_req and dm_req in IDLE: DM wins unless starve_cnt==STARVE_LIMIT.
- mem_ready while not in BUSY is ignored.
- mem_req is held continuously through a multi-cycle BUSY.
- stall signals are combinational from req and done, and are 0 during reset.

## Test plan
- Reset: assert rst mid-BUSY with mem_req=1 → all outputs 0 on the same cycle; after release, no done pulse appears and the FSM is in IDLE.
- Single fetch, slow memory: if_addr=0x0000_1000, mem_ready 2 cycles after mem_req rises, mem_rdata=0x0050_0093 → mem_req high for 2 cycles, mem_addr=0x1000, mem_we=0, if_done high for exactly 1 cycle with if_rdata=0x0050_0093, if_stall low in that cycle.
- Contention: if_req and dm_req (load, addr 0x2000) rise together → dm served first (grant_dm); IF granted in the IDLE cycle after dm_done; if_done follows; starve_cnt ends at 0.
- Store: dm_we=1, dm_addr=0x0000_0040, dm_wdata=0xDEAD_BEEF → mem_we=1, mem_wdata=0xDEAD_BEEF during BUSY; dm_done pulses; dm_rdata retains its previous value.
- Starvation, STARVE_LIMIT=4: dm_req held high across back-to-back loads with if_req held high → exactly 4 DM grants, then an IF grant, then DM again; starve_cnt clears after the IF grant.
- Input instability: change if_addr from 0x1000 to 0x3000 during BUSY → mem_addr stays 0x1000 until RESP.
